// File: rtl/uart_mem_loader_pkg.sv
// uart_mem_loader_pkg: shared state encodings and word-width helper for the UART memory loader
package uart_mem_loader_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} ctl_state_t;
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_WAIT_HIGH} rx_state_t;
    function automatic int word_width(input int word_bytes);
        return 8 * word_bytes;
    endfunction
endpackage

// File: rtl/uart_mem_loader_if.sv
// uart_mem_loader_if: memory-side bus of the loader
// mem_write_start/addr/data: one-cycle write strobe with its word address and packed word
// mem_read: level handing the memory to the read side after a completed load
interface uart_mem_loader_if
    import uart_mem_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DW = word_width(4)
);
    logic              mem_write_start;
    logic [ADDR_W-1:0] mem_write_addr;
    logic [DW-1:0]     mem_write_data;
    logic              mem_read;
    modport master (output mem_write_start, mem_write_addr, mem_write_data, mem_read);
    modport slave  (input  mem_write_start, mem_write_addr, mem_write_data, mem_read);
endinterface

// File: rtl/uart_mem_loader_rx_core.sv
// uart_rx_core: oversampling-free UART byte receiver with optional parity
// clk/reset: system clock, async active-low reset; tx: raw serial line (idle high)
// byte_valid/byte_data: one-cycle pulse with the received byte
// frame_err_p/parity_err_p: one-cycle error pulses, the byte is discarded
module uart_rx_core
    import uart_mem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 261,
    parameter int PARITY_EN = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err_p,
    output logic       parity_err_p
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    rx_state_t state, state_n;
    logic s1, s2, prev;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] idx, idx_n;
    logic [7:0] sh_n;
    logic par, par_n, par_ok, bv_n, fe_n, pe_n;
    // data plus parity bit must carry the configured overall parity
    assign par_ok = (PARITY_EN == 0) || ((^{byte_data, par}) == 1'(PARITY_ODD));
    always_comb begin
        state_n = state;
        cnt_n = cnt + 1'b1;
        idx_n = idx;
        sh_n = byte_data;
        par_n = par;
        bv_n = 1'b0;
        fe_n = 1'b0;
        pe_n = 1'b0;
        case (state)
            R_IDLE: begin
                cnt_n = '0;
                if (prev && !s2) state_n = R_START;
            end
            R_START: if (cnt == HALF) begin
                cnt_n = '0;
                idx_n = '0;
                state_n = s2 ? R_IDLE : R_DATA;
            end
            R_DATA: if (cnt == LAST) begin
                cnt_n = '0;
                sh_n = {s2, byte_data[7:1]};
                idx_n = idx + 1'b1;
                if (idx == 3'd7) state_n = (PARITY_EN != 0) ? R_PAR : R_STOP;
            end
            R_PAR: if (cnt == LAST) begin
                cnt_n = '0;
                par_n = s2;
                state_n = R_STOP;
            end
            R_STOP: if (cnt == LAST) begin
                cnt_n = '0;
                fe_n = !s2;
                pe_n = s2 && !par_ok;
                bv_n = s2 && par_ok;
                state_n = s2 ? R_IDLE : R_WAIT_HIGH;
            end
            R_WAIT_HIGH: begin
                cnt_n = '0;
                if (s2) state_n = R_IDLE;
            end
            default: state_n = R_IDLE;
        endcase
    end
    // synchroniser and edge history reset high so a reset never fakes a start edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            prev <= 1'b1;
            state <= R_IDLE;
            cnt <= '0;
            idx <= '0;
            byte_data <= '0;
            par <= 1'b0;
            byte_valid <= 1'b0;
            frame_err_p <= 1'b0;
            parity_err_p <= 1'b0;
        end else begin
            s1 <= tx;
            s2 <= s1;
            prev <= s2;
            state <= state_n;
            cnt <= cnt_n;
            idx <= idx_n;
            byte_data <= sh_n;
            par <= par_n;
            byte_valid <= bv_n;
            frame_err_p <= fe_n;
            parity_err_p <= pe_n;
        end
    end
endmodule

// File: rtl/uart_mem_loader.sv
// uart_mem_loader: packs UART bytes little-endian into words and writes them to memory
// clk/reset: system clock, async active-low reset; tx: serial line from host
// load_start/word_number: start a load of word_number words (accepted in IDLE or DONE)
// busy: high in LOAD and WRITE; frame_err/parity_err: sticky receive errors
// mem: write strobe/address/data and mem_read hand-over level
module uart_mem_loader
    import uart_mem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 261,
    parameter int WORD_BYTES = 4,
    parameter int ADDR_W = 8,
    parameter int PARITY_EN = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] word_number,
    output logic              busy,
    output logic              frame_err,
    output logic              parity_err,
    uart_mem_loader_if.master mem
);
    localparam int DW = word_width(WORD_BYTES);
    localparam int BW = WORD_BYTES > 1 ? $clog2(WORD_BYTES) : 1;
    localparam logic [BW-1:0] LAST_B = BW'(WORD_BYTES - 1);
    ctl_state_t state, state_n;
    logic [ADDR_W-1:0] wn, wn_n, waddr, waddr_n, waddr_inc, oaddr, oaddr_n;
    logic [BW-1:0] bcnt, bcnt_n;
    logic [DW-1:0] word, word_n, packed_w, odata, odata_n;
    logic strobe, strobe_n, rd, rd_n, busy_n, fe_n, pe_n;
    logic bv, rx_fe, rx_pe;
    logic [7:0] rx_data;
    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .PARITY_EN(PARITY_EN),
        .PARITY_ODD(PARITY_ODD)
    ) u_rx (
        .clk(clk),
        .reset(reset),
        .tx(tx),
        .byte_valid(bv),
        .byte_data(rx_data),
        .frame_err_p(rx_fe),
        .parity_err_p(rx_pe)
    );
    // new byte enters at the top so the first byte ends up in bits [7:0]
    assign packed_w = (word >> 8) | (DW'(rx_data) << (DW - 8));
    assign waddr_inc = waddr + 1'b1;
    assign mem.mem_write_start = strobe;
    assign mem.mem_write_addr = oaddr;
    assign mem.mem_write_data = odata;
    assign mem.mem_read = rd;
    always_comb begin
        state_n = state;
        wn_n = wn;
        waddr_n = waddr;
        oaddr_n = oaddr;
        bcnt_n = bcnt;
        word_n = word;
        odata_n = odata;
        strobe_n = 1'b0;
        rd_n = rd;
        fe_n = frame_err | rx_fe;
        pe_n = parity_err | rx_pe;
        case (state)
            IDLE, DONE: if (load_start) begin
                state_n = LOAD;
                wn_n = word_number;
                waddr_n = '0;
                bcnt_n = '0;
                rd_n = 1'b0;
                fe_n = 1'b0;
                pe_n = 1'b0;
            end
            LOAD: if (wn == '0) begin
                state_n = DONE;
                rd_n = 1'b1;
            end else if (bv) begin
                word_n = packed_w;
                bcnt_n = bcnt + 1'b1;
                // strobe is raised on entry so it is high for exactly the WRITE cycle
                if (bcnt == LAST_B) begin
                    state_n = WRITE;
                    strobe_n = 1'b1;
                    oaddr_n = waddr;
                    odata_n = packed_w;
                end
            end
            WRITE: begin
                waddr_n = waddr_inc;
                bcnt_n = '0;
                state_n = (waddr_inc == wn) ? DONE : LOAD;
                rd_n = (waddr_inc == wn);
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n == LOAD) || (state_n == WRITE);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            wn <= '0;
            waddr <= '0;
            oaddr <= '0;
            bcnt <= '0;
            word <= '0;
            odata <= '0;
            strobe <= 1'b0;
            rd <= 1'b0;
            busy <= 1'b0;
            frame_err <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            state <= state_n;
            wn <= wn_n;
            waddr <= waddr_n;
            oaddr <= oaddr_n;
            bcnt <= bcnt_n;
            word <= word_n;
            odata <= odata_n;
            strobe <= strobe_n;
            rd <= rd_n;
            busy <= busy_n;
            frame_err <= fe_n;
            parity_err <= pe_n;
        end
    end
endmodule

// File: tb/tb_uart_mem_loader.sv
// tb_uart_mem_loader: directed scoreboard bench for two loader configurations
module tb_uart_mem_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tx1 = 1'b1, tx2 = 1'b1, ls1 = 1'b0, ls2 = 1'b0;
    logic [7:0] wn1 = '0, wn2 = '0;
    logic busy1, fe1, pe1, busy2, fe2, pe2;
    uart_mem_loader_if #(.ADDR_W(8), .DW(32)) m1();
    uart_mem_loader_if #(.ADDR_W(8), .DW(16)) m2();
    uart_mem_loader #(.CLKS_PER_BIT(261), .WORD_BYTES(4), .ADDR_W(8), .PARITY_EN(0), .PARITY_ODD(0)) dut1 (
        .clk(clk), .reset(reset), .tx(tx1), .load_start(ls1), .word_number(wn1),
        .busy(busy1), .frame_err(fe1), .parity_err(pe1), .mem(m1));
    uart_mem_loader #(.CLKS_PER_BIT(16), .WORD_BYTES(2), .ADDR_W(8), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
        .clk(clk), .reset(reset), .tx(tx2), .load_start(ls2), .word_number(wn2),
        .busy(busy2), .frame_err(fe2), .parity_err(pe2), .mem(m2));
    always #50 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        int          cyc;
        bit          last;
    } exp_t;
    exp_t sb1[$], sb2[$], arm_e, e1, e2;
    bit arm = 0, chk1 = 0, chk2 = 0, last1 = 0, last2 = 0;
    int total = 0, bad = 0, n1 = 0, n2 = 0, nbase = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic v);
        if (d != 0) tx2 = v;
        else tx1 = v;
    endtask

    // strobe expected CLKS_PER_BIT/2 + 4 cycles after the stop bit starts
    task automatic send(input int d, input logic [7:0] b, input logic par, input logic stop);
        int cpb = (d != 0) ? 16 : 261;
        drive(d, 1'b0);
        wait_cyc(cpb);
        for (int i = 0; i < 8; i++) begin
            drive(d, b[i]);
            wait_cyc(cpb);
        end
        if (d != 0) begin
            drive(d, par);
            wait_cyc(cpb);
        end
        drive(d, stop);
        if (arm) begin
            arm_e.cyc = cyc + cpb / 2 + 4;
            if (d != 0) sb2.push_back(arm_e);
            else sb1.push_back(arm_e);
            arm = 0;
        end
        wait_cyc(cpb);
        drive(d, 1'b1);
        wait_cyc(20);
    endtask

    task automatic expect_w(input logic [7:0] a, input logic [31:0] dat, input bit l);
        arm = 1;
        arm_e.addr = a;
        arm_e.data = dat;
        arm_e.last = l;
    endtask

    task automatic start(input int d, input logic [7:0] n);
        if (d != 0) begin
            ls2 = 1'b1;
            wn2 = n;
        end else begin
            ls1 = 1'b1;
            wn1 = n;
        end
        wait_cyc(1);
        ls1 = 1'b0;
        ls2 = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk1) begin
            chk("rd_after_strobe1", m1.mem_read, last1);
            chk("busy_after_strobe1", busy1, !last1);
            chk1 = 0;
        end
        if (m1.mem_write_start === 1'b1) begin
            n1++;
            chk("strobe_expected1", sb1.size() != 0, 1);
            if (sb1.size() != 0) begin
                e1 = sb1.pop_front();
                chk("addr1", m1.mem_write_addr, e1.addr);
                chk("data1", m1.mem_write_data, e1.data);
                chk("strobe_cycle1", cyc, e1.cyc);
                chk1 = 1;
                last1 = e1.last;
            end
        end
        if (chk2) begin
            chk("rd_after_strobe2", m2.mem_read, last2);
            chk("busy_after_strobe2", busy2, !last2);
            chk2 = 0;
        end
        if (m2.mem_write_start === 1'b1) begin
            n2++;
            chk("strobe_expected2", sb2.size() != 0, 1);
            if (sb2.size() != 0) begin
                e2 = sb2.pop_front();
                chk("addr2", m2.mem_write_addr, e2.addr);
                chk("data2", m2.mem_write_data, e2.data);
                chk("strobe_cycle2", cyc, e2.cyc);
                chk2 = 1;
                last2 = e2.last;
            end
        end
    end

    initial begin
        #5 reset = 1'b0;
        wait_cyc(3);
        chk("reset_out1", {m1.mem_write_start, m1.mem_write_addr, m1.mem_write_data, m1.mem_read, busy1, fe1, pe1}, 0);
        chk("reset_out2", {m2.mem_write_start, m2.mem_write_addr, m2.mem_write_data, m2.mem_read, busy2, fe2, pe2}, 0);
        reset = 1'b1;
        wait_cyc(3);
        // odd parity, 2-byte words: first 0xA5 carries a wrong parity bit
        start(1, 8'd1);
        chk("busy2_load", busy2, 1);
        send(1, 8'hA5, 1'b0, 1'b1);
        chk("parity_err2", pe2, 1);
        chk("frame_err2", fe2, 0);
        send(1, 8'hA5, 1'b1, 1'b1);
        expect_w(8'd0, 32'h5AA5, 1);
        send(1, 8'h5A, 1'b1, 1'b1);
        chk("mem_read2", m2.mem_read, 1);
        chk("strobes2", n2, 1);
        // basic two-word load
        start(0, 8'd2);
        chk("busy1_load", busy1, 1);
        chk("mem_read1_load", m1.mem_read, 0);
        send(0, 8'h11, 1'b0, 1'b1);
        send(0, 8'h22, 1'b0, 1'b1);
        send(0, 8'h33, 1'b0, 1'b1);
        expect_w(8'd0, 32'h44332211, 0);
        send(0, 8'h44, 1'b0, 1'b1);
        send(0, 8'h55, 1'b0, 1'b1);
        send(0, 8'h66, 1'b0, 1'b1);
        send(0, 8'h77, 1'b0, 1'b1);
        expect_w(8'd1, 32'h88776655, 1);
        send(0, 8'h88, 1'b0, 1'b1);
        chk("mem_read1_done", m1.mem_read, 1);
        chk("busy1_done", busy1, 0);
        chk("addr1_hold", m1.mem_write_addr, 1);
        chk("data1_hold", m1.mem_write_data, 32'h88776655);
        chk("strobes1_basic", n1, 2);
        // zero-length load
        start(0, 8'd0);
        chk("zero_rd_clear", m1.mem_read, 0);
        chk("zero_busy", busy1, 1);
        wait_cyc(1);
        chk("zero_rd_set", m1.mem_read, 1);
        chk("zero_busy_done", busy1, 0);
        chk("strobes1_zero", n1, 2);
        // framing error on third byte, then resent
        start(0, 8'd1);
        send(0, 8'h11, 1'b0, 1'b1);
        send(0, 8'h22, 1'b0, 1'b1);
        send(0, 8'h33, 1'b0, 1'b0);
        chk("frame_err1", fe1, 1);
        chk("parity_err1_frame", pe1, 0);
        send(0, 8'h33, 1'b0, 1'b1);
        expect_w(8'd0, 32'h44332211, 1);
        send(0, 8'h44, 1'b0, 1'b1);
        chk("frame_err1_sticky", fe1, 1);
        // glitch shorter than half a bit
        start(0, 8'd1);
        chk("frame_err1_cleared", fe1, 0);
        tx1 = 1'b0;
        wait_cyc(100);
        tx1 = 1'b1;
        wait_cyc(300);
        chk("glitch_fe", fe1, 0);
        chk("glitch_pe", pe1, 0);
        chk("glitch_busy", busy1, 1);
        send(0, 8'hDE, 1'b0, 1'b1);
        send(0, 8'hAD, 1'b0, 1'b1);
        send(0, 8'hBE, 1'b0, 1'b1);
        expect_w(8'd0, 32'hEFBEADDE, 1);
        send(0, 8'hEF, 1'b0, 1'b1);
        chk("glitch_rd", m1.mem_read, 1);
        // reset during the second data bit of byte 3
        start(0, 8'd2);
        send(0, 8'h01, 1'b0, 1'b1);
        send(0, 8'h02, 1'b0, 1'b1);
        tx1 = 1'b0;
        wait_cyc(261);
        tx1 = 1'b1;
        wait_cyc(261);
        tx1 = 1'b1;
        wait_cyc(130);
        #20 reset = 1'b0;
        #1;
        chk("midreset_out1", {m1.mem_write_start, m1.mem_write_addr, m1.mem_write_data, m1.mem_read, busy1, fe1, pe1}, 0);
        wait_cyc(5);
        reset = 1'b1;
        wait_cyc(5);
        nbase = n1;
        start(0, 8'd1);
        send(0, 8'h10, 1'b0, 1'b1);
        send(0, 8'h20, 1'b0, 1'b1);
        send(0, 8'h30, 1'b0, 1'b1);
        expect_w(8'd0, 32'h40302010, 1);
        send(0, 8'h40, 1'b0, 1'b1);
        chk("post_reset_strobes", n1 - nbase, 1);
        chk("post_reset_rd", m1.mem_read, 1);
        wait_cyc(5);
        chk("pending1", sb1.size(), 0);
        chk("pending2", sb2.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
